// File: rtl/doa_pkg.sv
// Shared DOA datapath widths and the frame-control state type.
package doa_pkg;
  localparam int unsigned DOA_NCH    = 4;
  localparam int unsigned DOA_PROD_W = 25;
  localparam int unsigned DOA_ACC_W  = 32;
  localparam int unsigned DOA_CNT_W  = 16;

  typedef enum logic {
    FRAME_IDLE  = 1'b0,
    FRAME_ACCUM = 1'b1
  } frame_state_e;
endpackage

// File: rtl/accum_lane.sv
// One correlation channel: sign-extend, load-or-add, optional clamp and sticky sat.
// Saturating arithmetic and the sat flag are built only with ACCUM_SAT_EN defined.
module accum_lane
  import doa_pkg::*;
#(
  parameter int unsigned IN_W  = DOA_PROD_W,
  parameter int unsigned ACC_W = DOA_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_first,
  input  logic [IN_W-1:0]  i_x,
  output logic [ACC_W-1:0] o_sum_c
`ifdef ACCUM_SAT_EN
  ,
  output logic             o_sat_c
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;

  assign ext = ACC_W'($signed(i_x));
  assign raw = acc + ext;

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf;
  logic sat;

  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf = !i_first && (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    o_sum_c = raw;
    if (i_first)  o_sum_c = ext;
    else if (ovf) o_sum_c = acc[ACC_W-1] ? MIN_NEG : MAX_POS;
  end

  assign o_sat_c = ovf | (!i_first & sat);

  always_ff @(posedge i_clk) begin
    if (i_rst)     sat <= 1'b0;
    else if (i_en) sat <= o_sat_c;
  end
`else
  assign o_sum_c = i_first ? ext : raw;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)     acc <= '0;
    else if (i_en) acc <= o_sum_c;
  end

endmodule

// File: rtl/corr_accum_mc.sv
// Multi-channel per-frame correlation accumulator with count, valid/ready output and overrun.
// Optional per-channel saturation enabled by defining ACCUM_SAT_EN.
module corr_accum_mc
  import doa_pkg::*;
#(
  parameter int unsigned NCH   = DOA_NCH,
  parameter int unsigned IN_W  = DOA_PROD_W,
  parameter int unsigned ACC_W = DOA_ACC_W,
  parameter int unsigned CNT_W = DOA_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH*IN_W-1:0]  i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic                 i_clear,
  output logic [NCH*ACC_W-1:0] o_accum,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  output logic [NCH-1:0]       o_sat
);

  frame_state_e state, state_nxt;

  logic                 first;
  logic                 beat;
  logic                 done;
  logic                 drain;
  logic                 load;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_c;
  logic [NCH*ACC_W-1:0] sum_c;

  assign first = (state == FRAME_IDLE);
  assign beat  = i_valid & ~i_clear;
  assign done  = beat & i_last;
  assign drain = o_valid & i_ready;
  assign load  = done & (~o_valid | i_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FRAME_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear)   state_nxt = FRAME_IDLE;
    else if (beat) state_nxt = i_last ? FRAME_IDLE : FRAME_ACCUM;
  end

  // Sample count including the current beat; sticks at all-ones.
  assign cnt_c = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst)     cnt <= '0;
    else if (beat) cnt <= cnt_c;
  end

`ifdef ACCUM_SAT_EN
  logic [NCH-1:0] sat_c;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    accum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (beat),
      .i_first (first),
      .i_x     (i_data[k*IN_W +: IN_W]),
      .o_sum_c (sum_c[k*ACC_W +: ACC_W])
`ifdef ACCUM_SAT_EN
      ,
      .o_sat_c (sat_c[k])
`endif
    );
  end

  // Output register: a completing frame loads only when the slot is free or draining.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_accum   <= '0;
      o_count   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (load) begin
        o_accum <= sum_c;
        o_count <= cnt_c;
        o_valid <= 1'b1;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
      if (done && !load) o_overrun <= 1'b1;
    end
  end

`ifdef ACCUM_SAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_sat <= '0;
    else if (load) o_sat <= sat_c;
  end
`else
  assign o_sat = '0;
`endif

endmodule

// File: tb/tb_corr_accum_mc.sv
// Self-checking bench: a 4-channel default instance and a 1-channel narrow instance.
module tb_corr_accum_mc;

  logic clk;
  logic rst;

  // Instance A: defaults (NCH=4, IN_W=25, ACC_W=32, CNT_W=16)
  logic [99:0]  a_data;
  logic         a_valid, a_last, a_clear, a_ready;
  logic [127:0] a_accum;
  logic [15:0]  a_count;
  logic         a_ovalid, a_ovr;
  logic [3:0]   a_sat;

  // Instance B: NCH=1, IN_W=25, ACC_W=26, CNT_W=3
  logic [24:0]  b_data;
  logic         b_valid, b_last, b_clear, b_ready;
  logic [25:0]  b_accum;
  logic [2:0]   b_count;
  logic         b_ovalid, b_ovr;
  logic [0:0]   b_sat;

  int checks = 0;
  int errors = 0;

  longint a_x [4];
  longint a_exp [4];

  corr_accum_mc dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .i_last(a_last),
    .i_clear(a_clear), .o_accum(a_accum), .o_count(a_count), .o_valid(a_ovalid),
    .i_ready(a_ready), .o_overrun(a_ovr), .o_sat(a_sat)
  );

  corr_accum_mc #(.NCH(1), .IN_W(25), .ACC_W(26), .CNT_W(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .i_last(b_last),
    .i_clear(b_clear), .o_accum(b_accum), .o_count(b_count), .o_valid(b_ovalid),
    .i_ready(b_ready), .o_overrun(b_ovr), .o_sat(b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: exact sum, then clamp or two's-complement wrap at w bits.
  function automatic longint model_add(input longint a, input longint b, input int w,
                                       inout bit sat);
    longint s, hi, lo;
    s  = a + b;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
`ifdef ACCUM_SAT_EN
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
`else
    if (s > hi) s = s - (longint'(1) <<< w);
    else if (s < lo) s = s + (longint'(1) <<< w);
`endif
    return s;
  endfunction

  function automatic longint rand_prod();
    longint v;
    v = longint'($urandom_range(0, 32'h01FF_FFFF));
    if (v >= (longint'(1) <<< 24)) v = v - (longint'(1) <<< 25);
    return v;
  endfunction

  function automatic longint a_ch(input int k);
    return longint'($signed(a_accum[k*32 +: 32]));
  endfunction

  task automatic a_step(input bit v, input bit l, input bit c);
    for (int k = 0; k < 4; k++) a_data[k*25 +: 25] = 25'(a_x[k]);
    a_valid = v; a_last = l; a_clear = c;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0; a_clear = 1'b0;
  endtask

  task automatic b_step(input bit v, input bit l, input longint x);
    b_data = 25'(x); b_valid = v; b_last = l;
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; a_last = 0; a_clear = 0; b_valid = 0; b_last = 0; b_clear = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_accum !== '0 || a_count !== '0 || a_ovalid !== 1'b0 || a_ovr !== 1'b0 || a_sat !== '0) begin
      errors++; $display("FAIL reset_a: accum=%0h count=%0d valid=%0b ovr=%0b sat=%0b, want all 0", a_accum, a_count, a_ovalid, a_ovr, a_sat);
    end
    checks++; if (b_accum !== '0 || b_count !== '0 || b_ovalid !== 1'b0 || b_ovr !== 1'b0 || b_sat !== '0) begin
      errors++; $display("FAIL reset_b: accum=%0h count=%0d valid=%0b ovr=%0b sat=%0b, want all 0", b_accum, b_count, b_ovalid, b_ovr, b_sat);
    end
    // Reset mid-frame must drop the partial sums.
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) a_x[k] = 1000 + k;
    a_step(1, 0, 0);
    a_step(1, 0, 0);
    do_reset();
    for (int k = 0; k < 4; k++) a_x[k] = 7;
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== 64'sd7) begin
        errors++; $display("FAIL reset_midframe_ch%0d: got %0d want 7", k, a_ch(k));
      end
    end
    checks++; if (a_count !== 16'd1 || a_ovalid !== 1'b1) begin
      errors++; $display("FAIL reset_midframe_cnt: count=%0d valid=%0b want 1/1", a_count, a_ovalid);
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    b_ready = 1'b1;
    b_step(1, 0, 3);
    b_step(1, 0, -5);
    b_step(1, 1, 10);
    checks++; if (b_accum !== 26'd8 || b_count !== 3'd3 || b_ovalid !== 1'b1) begin
      errors++; $display("FAIL single_channel: accum=%0d count=%0d valid=%0b want 8/3/1", $signed(b_accum), b_count, b_ovalid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) a_x[k] = k + 1;
    a_step(1, 0, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 10 * (k + 1);
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== longint'(11 * (k + 1))) begin
        errors++; $display("FAIL b2b_f1_ch%0d: got %0d want %0d", k, a_ch(k), 11 * (k + 1));
      end
    end
    checks++; if (a_count !== 16'd2 || a_ovalid !== 1'b1) begin
      errors++; $display("FAIL b2b_f1_cnt: count=%0d valid=%0b want 2/1", a_count, a_ovalid);
    end
    for (int k = 0; k < 4; k++) a_x[k] = k + 5;
    a_step(1, 0, 0);
    checks++; if (a_ovalid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: valid=%0b want 0", a_ovalid);
    end
    for (int k = 0; k < 4; k++) a_x[k] = -(k + 1);
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== 64'sd4) begin
        errors++; $display("FAIL b2b_f2_ch%0d: got %0d want 4", k, a_ch(k));
      end
    end
    checks++; if (a_count !== 16'd2 || a_ovalid !== 1'b1 || a_ovr !== 1'b0) begin
      errors++; $display("FAIL b2b_f2_cnt: count=%0d valid=%0b ovr=%0b want 2/1/0", a_count, a_ovalid, a_ovr);
    end
  endtask

  task automatic test_idle_gaps();
    do_reset();
    a_ready = 1'b1;
    a_x[0] = 100; a_x[1] = -200; a_x[2] = 300; a_x[3] = -400;
    a_step(1, 0, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 999;
    repeat (3) a_step(0, 0, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 5;
    a_step(1, 1, 0);
    a_exp[0] = 105; a_exp[1] = -195; a_exp[2] = 305; a_exp[3] = -395;
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== a_exp[k]) begin
        errors++; $display("FAIL idle_gaps_ch%0d: got %0d want %0d", k, a_ch(k), a_exp[k]);
      end
    end
    checks++; if (a_count !== 16'd2) begin
      errors++; $display("FAIL idle_gaps_cnt: got %0d want 2", a_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    a_ready = 1'b0;
    for (int k = 0; k < 4; k++) a_x[k] = 3;
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 100;
    a_step(1, 0, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 50;
    a_step(1, 0, 1);
    checks++; if (a_ovalid !== 1'b1 || a_ch(0) !== 64'sd3 || a_count !== 16'd1) begin
      errors++; $display("FAIL clear_keeps_out: valid=%0b ch0=%0d count=%0d want 1/3/1", a_ovalid, a_ch(0), a_count);
    end
    // Drain and load in the same cycle: new vector replaces the old one.
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) a_x[k] = 7;
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== 64'sd7) begin
        errors++; $display("FAIL clear_frame_ch%0d: got %0d want 7", k, a_ch(k));
      end
    end
    checks++; if (a_count !== 16'd1 || a_ovalid !== 1'b1 || a_ovr !== 1'b0) begin
      errors++; $display("FAIL clear_frame_cnt: count=%0d valid=%0b ovr=%0b want 1/1/0", a_count, a_ovalid, a_ovr);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    a_ready = 1'b0;
    for (int k = 0; k < 4; k++) a_x[k] = k + 1;
    a_step(1, 0, 0);
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) a_x[k] = 9;
    a_step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_ch(k) !== longint'(2 * (k + 1))) begin
        errors++; $display("FAIL overrun_hold_ch%0d: got %0d want %0d", k, a_ch(k), 2 * (k + 1));
      end
    end
    checks++; if (a_count !== 16'd2 || a_ovalid !== 1'b1 || a_ovr !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: count=%0d valid=%0b ovr=%0b want 2/1/1", a_count, a_ovalid, a_ovr);
    end
    a_ready = 1'b1;
    a_step(0, 0, 0);
    a_step(0, 0, 0);
    checks++; if (a_ovalid !== 1'b0 || a_ovr !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: valid=%0b ovr=%0b want 0/1", a_ovalid, a_ovr);
    end
  endtask

  task automatic test_count_saturate();
    do_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 9; i++) b_step(1, 0, 1);
    b_step(1, 1, 1);
    checks++; if (b_count !== 3'd7 || b_accum !== 26'd10) begin
      errors++; $display("FAIL count_saturate: count=%0d accum=%0d want 7/10", b_count, $signed(b_accum));
    end
  endtask

  task automatic test_saturation();
    longint mx, e;
    bit s;
    do_reset();
    b_ready = 1'b1;
    mx = (longint'(1) <<< 24) - 1;
    s = 1'b0;
    e = mx;
    e = model_add(e, mx, 26, s);
    e = model_add(e, mx, 26, s);
    b_step(1, 0, mx);
    b_step(1, 0, mx);
    b_step(1, 1, mx);
    checks++; if (longint'($signed(b_accum)) !== e || b_sat[0] !== s) begin
      errors++; $display("FAIL saturation: accum=%0d sat=%0b want %0d/%0b", $signed(b_accum), b_sat[0], e, s);
    end
    b_step(1, 1, 1);
    checks++; if (b_accum !== 26'd1 || b_sat[0] !== 1'b0) begin
      errors++; $display("FAIL sat_per_frame: accum=%0d sat=%0b want 1/0", $signed(b_accum), b_sat[0]);
    end
  endtask

  task automatic test_random();
    int n;
    bit s;
    do_reset();
    a_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 6);
      s = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          a_x[k] = rand_prod();
          a_exp[k] = (i == 0) ? a_x[k] : model_add(a_exp[k], a_x[k], 32, s);
        end
        a_step(1, (i == n - 1), 0);
        if (i != n - 1 && $urandom_range(0, 3) == 0) a_step(0, 0, 0);
      end
      for (int k = 0; k < 4; k++) begin
        checks++; if (a_ch(k) !== a_exp[k]) begin
          errors++; $display("FAIL random_f%0d_ch%0d: got %0d want %0d", f, k, a_ch(k), a_exp[k]);
        end
      end
      checks++; if (a_count !== 16'(n) || a_ovalid !== 1'b1 || a_sat !== 4'b0) begin
        errors++; $display("FAIL random_f%0d_cnt: count=%0d valid=%0b sat=%0b want %0d/1/0", f, a_count, a_ovalid, a_sat, n);
      end
      if ($urandom_range(0, 2) == 0) a_step(0, 0, 0);
    end
    checks++; if (a_ovr !== 1'b0 || b_ovr !== 1'b0) begin
      errors++; $display("FAIL random_overrun: a=%0b b=%0b want 0/0", a_ovr, b_ovr);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = 0; a_last = 0; a_clear = 0; a_ready = 0;
    b_data = '0; b_valid = 0; b_last = 0; b_clear = 0; b_ready = 0;
    for (int k = 0; k < 4; k++) a_x[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_channel();
    test_back_to_back();
    test_idle_gaps();
    test_clear();
    test_overrun();
    test_count_saturate();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_accum_mc.md
# corr_accum_mc

Multi-channel, parametrised successor to the single-lane correlation accumulator in the DOA datapath. It sums `NCH` signed correlation products per frame, where `i_last` marks the end of a frame. It adds a sample count, a valid/ready output handshake and overrun detection. It sits between the per-pair correlation multipliers and the covariance/spectrum stage, and delivers one vector of `NCH` sums per frame.

## Interface
Parameters:
- `NCH`, 4: number of independent channels (antenna-pair products), ≥1
- `IN_W`, 25: signed width of each input product
- `ACC_W`, 32: signed accumulator/output width per channel, ≥ `IN_W`
- `CNT_W`, 16: width of the per-frame sample counter

Ports:
- `i_clk`  in  1  clock; all logic rising-edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_data`  in  `NCH*IN_W`  packed signed products; channel k at `[k*IN_W +: IN_W]`
- `i_valid`  in  1  `i_data`/`i_last` qualify this cycle
- `i_last`  in  1  final sample of the frame; ignored unless `i_valid`
- `i_clear`  in  1  abort the current frame; discard partial sums
- `o_accum`  out  `NCH*ACC_W`  packed signed frame sums, same channel packing
- `o_count`  out  `CNT_W`  samples in the reported frame
- `o_valid`  out  1  output vector valid
- `i_ready`  in  1  downstream accepts when `o_valid && i_ready`
- `o_overrun`  out  1  sticky; a completed frame found the output register still occupied
- `o_sat`  out  `NCH`  per-channel saturation seen in the reported frame (only with `ACCUM_SAT_EN`; tied 0 otherwise)

## Operation
- Internal state per channel: accumulator `acc[k]`. Shared state: `cnt` and a `first` flag (set means the next valid sample starts a frame).
- Each input is sign-extended from `IN_W` to `ACC_W` before the add.
- Valid beat with `first`=1: `acc[k] <= ext(x)`, `cnt <= 1`, `first <= 0`. The previous frame is never added in.
- Valid beat with `first`=0: `acc[k] <= acc[k] + ext(x)`, `cnt <= cnt + 1`.
- Idle cycles (`i_valid`=0) hold `acc` and `cnt`. Idle does not clear the accumulators.
- Valid beat with `i_last`=1:
  - The sums including this beat are copied to the output register, with `o_count = cnt+1` (1 if `first`).
  - `first <= 1`.
- Output register behaviour:
  - It loads on a completing beat when it is empty or is being drained in the same cycle.
  - Otherwise the new frame is dropped, the old output is held, and `o_overrun <= 1`.
- `o_overrun` clears only on reset.
- `cnt` saturates at all-ones and does not wrap.
- `i_clear` sets `first <= 1` and has priority over a simultaneous valid beat, which is discarded. It does not affect the output register.
- Frame state machine has two states:
  - `IDLE` (`first`=1) → `ACCUM` on a valid beat with `i_last`=0.
  - `ACCUM` → `IDLE` on a valid beat with `i_last`=1, or on `i_clear`.
  - `IDLE` → `IDLE` on a single-sample frame (valid beat with `i_last`=1).

## Timing
- Reset values:
  - `o_accum`=0, `o_count`=0, `o_valid`=0, `o_overrun`=0, `o_sat`=0.
  - Internal: `acc`=0, `cnt`=0, `first`=1.
- Latency: the sum vector is registered in the cycle after the `i_last` beat.
- Throughput: one sample per cycle. Back-to-back frames are allowed with no gap cycle.
- The input side has no backpressure. Upstream never stalls; overrun is the only indication of lost data.
- If `o_valid` is set and `i_ready` is high while a new frame completes in the same cycle, the new vector loads and `o_valid` stays 1.
- `o_valid` stays high, with its data stable, until accepted.
- Reset asserted mid-frame discards all state on the next edge.

## Configuration
- `ACCUM_SAT_EN` defined:
  - Each add clamps to `[-2^(ACC_W-1), 2^(ACC_W-1)-1]`.
  - Any clamp in a frame sets that channel's bit in `o_sat` for that frame's output.
- `ACCUM_SAT_EN` undefined:
  - Two's-complement wrap at `ACC_W`.
  - `o_sat` tied to 0.

## Structure
- Shared package `doa_pkg`: default widths `DOA_NCH`, `DOA_PROD_W`, `DOA_ACC_W`, `DOA_CNT_W`, and the 2-state frame enum.
- One sub-module `accum_lane`, instantiated `NCH` times via generate. It holds one channel's sign-extend, add-or-load, optional saturation and sticky sat bit.
- Frame control, counter and output register live in the top module.

## Test plan
- Single channel, `NCH`=1, frame {3, -5, 10} with `i_last` on 10 → one cycle later `o_accum`=8, `o_count`=3, `o_valid`=1.
- `NCH`=4, two back-to-back 2-sample frames with `i_ready`=1:
  - Frame 1: {1,2,3,4} then {10,20,30,40} → outputs {11,22,33,44}.
  - Frame 2 → its own sums, with no carry-over from frame 1.
- Idle gaps inside a frame (valid, 3 idle cycles, valid+last) → sums unchanged by the gaps; `o_count`=2.
- `i_ready`=0 across two completed frames → first vector held; `o_overrun`=1; the second frame is lost.
- `i_clear` mid-frame, then frame {7} with `i_last` → `o_accum`=7, `o_count`=1.
- With `ACCUM_SAT_EN`, `ACC_W`=26, inputs of max positive `IN_W` value repeated → output clamps at 2^25-1 with `o_sat[0]`=1. Without the macro → the result wraps negative.
